ada_rr_mux: RTL and testbench

- Parametrised N-input, WIDTH-bit registered multiplexer with per-input valid/ready handshakes.
- Two modes: round-robin arbitration across requesting inputs, or fixed selection by a select port.
- Single-entry output register; sits between multiple producers (e.g. bus masters, writeback sources) and one consumer in the ADA pipeline/memory path.

---
 rtl/ada_rr_mux.sv | 94 +++++++++
 tb/tb_ada_rr_mux.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/ada_rr_mux.sv
// N-input registered multiplexer with valid/ready handshakes per channel.
// Round-robin or fixed-select arbitration feeds a single-entry output register.
module ada_rr_mux #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        select,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_src,
    output logic                    out_valid,
    input  logic                    out_ready
);

    localparam int NSEL = 1 << SEL_W;

    logic [SEL_W-1:0] ptr;
    logic [NSEL-1:0]  valid_ext;
    logic             acc;
    logic             grant_vld;
    logic [SEL_W-1:0] grant;
    logic [WIDTH-1:0] grant_data;
    logic             xfer;

    // Zero padding above NUM_IN makes an out-of-range select yield no grant.
    assign valid_ext = NSEL'(in_valid);
    assign acc       = !out_valid || out_ready;
    assign xfer      = acc && grant_vld;

    always_comb begin : grant_logic
        int               idx;
        logic [SEL_W-1:0] idx_s;
        // NOTE: every variable written in always_comb gets a default first,
        // otherwise a path that skips the assignment infers a latch.
        idx       = 0;
        idx_s     = '0;
        grant_vld = 1'b0;
        grant     = '0;
        if (mode) begin
            grant_vld = valid_ext[select];
            grant     = select;
        end else begin
            // Wrap modulo NUM_IN so non-power-of-2 builds never reach a ghost channel.
            for (int k = 1; k <= NUM_IN; k++) begin
                idx = int'(ptr) + k;
                if (idx >= NUM_IN) idx = idx - NUM_IN;
                idx_s = SEL_W'(idx);
                if (!grant_vld && valid_ext[idx_s]) begin
                    grant_vld = 1'b1;
                    grant     = idx_s;
                end
            end
        end
    end

    always_comb begin : data_mux
        grant_data = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (grant == SEL_W'(i)) grant_data = in_data[i*WIDTH +: WIDTH];
        end
    end

    always_comb begin : ready_decode
        in_ready = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            in_ready[i] = xfer && (grant == SEL_W'(i));
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            ptr       <= SEL_W'(NUM_IN - 1);
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= grant_data;
            out_src   <= grant;
            ptr       <= grant;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ada_rr_mux.sv
// Self-checking bench: three ada_rr_mux builds (4x32, 3x8, 8x8) driven in lockstep
// and compared each cycle against a behavioural arbitration model.
module tb_ada_rr_mux;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] d [8];
    logic [7:0]  v = '0;
    logic        mode = 1'b0;
    logic [2:0]  sel = '0;
    logic        out_ready = 1'b0;

    logic [127:0] data_a;
    logic [23:0]  data_b;
    logic [63:0]  data_c;
    logic [3:0]   rdy_a;
    logic [2:0]   rdy_b;
    logic [7:0]   rdy_c;
    logic [31:0]  od_a;
    logic [7:0]   od_b, od_c;
    logic [1:0]   src_a, src_b;
    logic [2:0]   src_c;
    logic         ov_a, ov_b, ov_c;

    logic [31:0] rdy_o [3];
    logic [31:0] od_o  [3];
    logic [31:0] src_o [3];
    logic [31:0] ov_o  [3];

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        int          n;
        int          w;
        int          sw;
        int          ptr;
        bit          ov;
        logic [31:0] od;
        int          src;
    } model_t;

    model_t m [3];

    always #5 clk = ~clk;

    assign data_a = {d[3], d[2], d[1], d[0]};
    assign data_b = {d[2][7:0], d[1][7:0], d[0][7:0]};
    always_comb begin
        data_c = '0;
        for (int i = 0; i < 8; i++) data_c[i*8 +: 8] = d[i][7:0];
    end

    assign rdy_o[0] = 32'(rdy_a);
    assign rdy_o[1] = 32'(rdy_b);
    assign rdy_o[2] = 32'(rdy_c);
    assign od_o[0]  = od_a;
    assign od_o[1]  = 32'(od_b);
    assign od_o[2]  = 32'(od_c);
    assign src_o[0] = 32'(src_a);
    assign src_o[1] = 32'(src_b);
    assign src_o[2] = 32'(src_c);
    assign ov_o[0]  = 32'(ov_a);
    assign ov_o[1]  = 32'(ov_b);
    assign ov_o[2]  = 32'(ov_c);

    ada_rr_mux #(.WIDTH(32), .NUM_IN(4), .SEL_W(2)) u_a (
        .clk(clk), .rst_n(rst_n), .in_data(data_a), .in_valid(v[3:0]), .in_ready(rdy_a),
        .mode(mode), .select(sel[1:0]), .out_data(od_a), .out_src(src_a),
        .out_valid(ov_a), .out_ready(out_ready)
    );

    ada_rr_mux #(.WIDTH(8), .NUM_IN(3), .SEL_W(2)) u_b (
        .clk(clk), .rst_n(rst_n), .in_data(data_b), .in_valid(v[2:0]), .in_ready(rdy_b),
        .mode(mode), .select(sel[1:0]), .out_data(od_b), .out_src(src_b),
        .out_valid(ov_b), .out_ready(out_ready)
    );

    ada_rr_mux #(.WIDTH(8), .NUM_IN(8), .SEL_W(3)) u_c (
        .clk(clk), .rst_n(rst_n), .in_data(data_c), .in_valid(v), .in_ready(rdy_c),
        .mode(mode), .select(sel), .out_data(od_c), .out_src(src_c),
        .out_valid(ov_c), .out_ready(out_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Channel that should win this cycle, or -1 when nobody is granted.
    function automatic int model_grant(int mi);
        int s;
        s = int'(sel) & ((1 << m[mi].sw) - 1);
        if (mode) return (s < m[mi].n && v[s[2:0]]) ? s : -1;
        for (int k = 1; k <= m[mi].n; k++) begin
            int idx;
            idx = (m[mi].ptr + k) % m[mi].n;
            if (v[idx[2:0]]) return idx;
        end
        return -1;
    endfunction

    // One clock: check ready before the edge, advance model, check outputs after.
    task automatic tick();
        int          g [3];
        bit          acc [3];
        logic [31:0] er;
        logic [31:0] mask;
        #1;
        for (int mi = 0; mi < 3; mi++) begin
            acc[mi] = !m[mi].ov || out_ready;
            g[mi]   = model_grant(mi);
            er      = (acc[mi] && g[mi] >= 0) ? (32'd1 << g[mi]) : 32'd0;
            check($sformatf("in_ready[%0d]", mi), rdy_o[mi], er);
        end
        @(posedge clk);
        for (int mi = 0; mi < 3; mi++) begin
            mask = (m[mi].w == 32) ? 32'hFFFF_FFFF : ((32'd1 << m[mi].w) - 32'd1);
            if (!rst_n) begin
                m[mi].ov  = 1'b0;
                m[mi].od  = '0;
                m[mi].src = 0;
                m[mi].ptr = m[mi].n - 1;
            end else if (acc[mi] && g[mi] >= 0) begin
                m[mi].ov  = 1'b1;
                m[mi].od  = d[g[mi]] & mask;
                m[mi].src = g[mi];
                m[mi].ptr = g[mi];
            end else if (out_ready) begin
                m[mi].ov = 1'b0;
            end
        end
        #1;
        for (int mi = 0; mi < 3; mi++) begin
            check($sformatf("out_valid[%0d]", mi), ov_o[mi], 32'(m[mi].ov));
            check($sformatf("out_data[%0d]", mi), od_o[mi], m[mi].od);
            check($sformatf("out_src[%0d]", mi), src_o[mi], 32'(m[mi].src));
        end
    endtask

    initial begin
        m[0] = '{n: 4, w: 32, sw: 2, ptr: 3, ov: 1'b0, od: '0, src: 0};
        m[1] = '{n: 3, w: 8,  sw: 2, ptr: 2, ov: 1'b0, od: '0, src: 0};
        m[2] = '{n: 8, w: 8,  sw: 3, ptr: 7, ov: 1'b0, od: '0, src: 0};
        for (int i = 0; i < 8; i++) d[i] = 32'hA0 + 32'(i);

        // Reset state
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        tick();
        check("reset_ov_a", 32'(ov_a), 32'd0);

        // Round-robin with every input valid: 0,1,2,3,0 on DUT A
        rst_n = 1'b1; v = 8'hFF; mode = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("rr_seq_src_a", 32'(src_a), 32'(k % 4));
            check("rr_seq_data_a", od_a, 32'hA0 + 32'(k % 4));
        end
        repeat (4) tick();

        // Backpressure: output held, nothing ready
        out_ready = 1'b0;
        repeat (3) begin
            tick();
            check("bp_rdy_a", 32'(rdy_a), 32'd0);
        end
        out_ready = 1'b1;
        repeat (2) tick();

        // Sparse requests on channels 0 and 2
        v = 8'b0000_0101;
        repeat (6) begin
            tick();
            check("sparse_rdy13_a", {30'd0, rdy_a[3], rdy_a[1]}, 32'd0);
        end

        // Fixed select 3, then 1 (DUT B has no channel 3 and must drain)
        v = 8'hFF; mode = 1'b1; sel = 3'd3;
        repeat (4) tick();
        check("fixed3_src_a", 32'(src_a), 32'd3);
        check("fixed3_drain_b", 32'(ov_b), 32'd0);
        sel = 3'd1;
        tick();
        check("fixed1_src_a", 32'(src_a), 32'd1);

        // Reset mid-stream with output stalled
        mode = 1'b0; out_ready = 1'b0;
        repeat (2) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; out_ready = 1'b1;
        tick();
        check("post_rst_src_a", 32'(src_a), 32'd0);
        check("post_rst_src_c", 32'(src_c), 32'd0);

        // Long round-robin run exercising wrap-around on all builds
        repeat (10) tick();

        // Randomized traffic with occasional reset
        for (int t = 0; t < 400; t++) begin
            for (int i = 0; i < 8; i++) d[i] = $urandom;
            v         = 8'($urandom);
            mode      = ($urandom_range(0, 3) == 0);
            sel       = 3'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            rst_n     = ($urandom_range(0, 49) != 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
